// File: rtl/keypad_matrix_scanner.sv
// Keypad matrix scanner: strobes active-low columns, debounces whole-matrix
// scans and reports single key presses over a valid/ack handshake.
module keypad_matrix_scanner #(
  parameter int COLS           = 4,
  parameter int ROWS           = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int CODE_W         = $clog2(ROWS*COLS)
) (
  input  logic              clock,
  input  logic              rst,
  output logic [COLS-1:0]   col_drive,
  input  logic [ROWS-1:0]   row_in,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              key_down
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int KEYS  = ROWS*COLS;

  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_SINGLE = 2'd1;
  localparam logic [1:0] RES_MULTI  = 2'd2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REPORT  = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v >= CNT_W'(DEBOUNCE_SCANS)) r = v;
    else                             r = v + CNT_W'(1);
    return r;
  endfunction

  // Bit index r*COLS+c of the image is already the key code of that switch.
  function automatic logic [CODE_W+1:0] classify(input logic [KEYS-1:0] img);
    logic [1:0]        n;
    logic [CODE_W-1:0] code;
    logic [1:0]        kind;
    n    = 2'd0;
    code = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (img[i]) begin
        if (n != 2'd2) n = n + 2'd1;
        code = CODE_W'(i);
      end
    end
    if (n == 2'd0)      kind = RES_NONE;
    else if (n == 2'd1) kind = RES_SINGLE;
    else                kind = RES_MULTI;
    return {kind, code};
  endfunction

  logic [ROWS-1:0]   row_sync_p0, row_sync_p1;
  logic [DIV_W-1:0]  dwell_cnt;
  logic [COL_W-1:0]  col_idx;
  logic [ROWS-1:0]   scan_img [COLS];
  logic              capture, eval;
  logic [KEYS-1:0]   img_now;
  logic [1:0]        res_kind;
  logic [CODE_W-1:0] res_code;
  logic [1:0]        cand_kind;
  logic [CODE_W-1:0] cand_code;
  logic [CNT_W-1:0]  match_cnt, match_nxt;
  logic              res_same, stab_load;
  logic [1:0]        stable_kind;
  logic [CODE_W-1:0] stable_code;
  logic              vld_p1;
  logic [1:0]        state;

  assign capture   = (dwell_cnt == DIV_W'(SCAN_DIV - 1));
  assign eval      = capture && (col_idx == COL_W'(COLS - 1));
  assign col_drive = ~(COLS'(1) << col_idx);

  // The last column is classified straight from the synchronizer so the
  // result is ready on the same edge that would capture it.
  always_comb begin
    img_now = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (c == COLS - 1) img_now[r*COLS+c] = ~row_sync_p1[r];
        else               img_now[r*COLS+c] = scan_img[c][r];
      end
    end
  end

  assign {res_kind, res_code} = classify(img_now);
  assign res_same  = (res_kind == cand_kind) &&
                     ((res_kind != RES_SINGLE) || (res_code == cand_code));
  assign match_nxt = res_same ? sat_inc(match_cnt) : CNT_W'(1);
  assign stab_load = eval && (match_nxt == CNT_W'(DEBOUNCE_SCANS));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      row_sync_p0 <= '1;
      row_sync_p1 <= '1;
      dwell_cnt   <= '0;
      col_idx     <= '0;
      cand_kind   <= RES_NONE;
      match_cnt   <= '0;
      stable_kind <= RES_NONE;
      key_down    <= 1'b0;
      vld_p1      <= 1'b0;
      state       <= ST_IDLE;
      key_valid   <= 1'b0;
      key_code    <= '0;
    end else begin
      // p0 -> p1: metastability guard on the asynchronous row returns
      row_sync_p0 <= row_in;
      row_sync_p1 <= row_sync_p0;

      if (capture) begin
        dwell_cnt <= '0;
        col_idx   <= (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
      end else begin
        dwell_cnt <= dwell_cnt + DIV_W'(1);
      end

      // p1: debounced result registered, FSM consumes it one cycle later
      vld_p1 <= eval;
      if (eval) begin
        cand_kind <= res_kind;
        match_cnt <= match_nxt;
      end
      if (stab_load) begin
        stable_kind <= res_kind;
        key_down    <= (res_kind != RES_NONE);
      end

      case (state)
        ST_IDLE: begin
          if (vld_p1 && stable_kind == RES_SINGLE) begin
            key_code  <= stable_code;
            key_valid <= 1'b1;
            state     <= ST_REPORT;
          end else if (vld_p1 && stable_kind == RES_MULTI) begin
            state <= ST_HELD;
          end
        end
        ST_REPORT: begin
          if (key_valid && key_ack) begin
            key_valid <= 1'b0;
            state     <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (vld_p1 && stable_kind == RES_NONE) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (capture) scan_img[col_idx] <= ~row_sync_p1;
    if (eval) cand_code <= res_code;
    if (stab_load) stable_code <= res_code;
  end

endmodule
